// File: rtl/mem_req_queue.sv
// mem_req_queue: in-order request buffer in front of a memory controller.
// Requests {rd_wr, addr, wdata} are queued in a DEPTH-entry FIFO. They are issued
// one at a time as a single-cycle registered command strobe. A read holds the
// issue path for RD_LATENCY cycles, then returns its data as a one-cycle response.
// Build option: define MEM_REQ_QUEUE_OVF_EN to compile in the sticky overflow
// flag (ovf_err). Without it, ovf_err is tied low.
module mem_req_queue #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_rd_wr,
    input  logic [ADDR_WIDTH-1:0]    req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     mc_rd_wr_valid,
    output logic                     mc_rd_wr,
    output logic [ADDR_WIDTH-1:0]    mc_addr,
    output logic [DATA_WIDTH-1:0]    mc_wr_data,
    input  logic [DATA_WIDTH-1:0]    mc_rd_data,
    output logic                     rsp_valid,
    output logic [ADDR_WIDTH-1:0]    rsp_addr,
    output logic [DATA_WIDTH-1:0]    rsp_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int EW = 1 + ADDR_WIDTH + DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;

    state_t                  state_q, state_d;
    logic [EW-1:0]           fifo_q [DEPTH];
    logic [EW-1:0]           fifo_d [DEPTH];
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]           level_q, level_d;
    logic [1:0]              cnt_q, cnt_d;
    logic                    mc_valid_q, mc_valid_d, mc_rd_wr_q, mc_rd_wr_d;
    logic [ADDR_WIDTH-1:0]   mc_addr_q, mc_addr_d, rsp_addr_q, rsp_addr_d;
    logic [DATA_WIDTH-1:0]   mc_wr_data_q, mc_wr_data_d, rsp_data_q, rsp_data_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    push, pop, not_empty;
    logic [EW-1:0]           head;

    // Accept only on level, so a pop in the same cycle never admits a push at full.
    assign req_ready = (level_q != LW'(DEPTH));
    assign push      = req_valid && req_ready;
    assign not_empty = (level_q != '0);
    assign head      = fifo_q[rd_ptr_q];

    // FIFO storage, pointers and occupancy.
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            fifo_d[wr_ptr_q] = {req_rd_wr, req_addr, req_wdata};
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
    end

    // Issue sequencing: a pop is the edge that loads a command into the mc_* registers.
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_addr_d  = rsp_addr_q;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (not_empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (mc_rd_wr_q) begin
                    state_d = RD_WAIT;
                    cnt_d   = 2'(RD_LATENCY - 1);
                end else if (not_empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_WAIT: begin
                if (cnt_q == 2'd0) begin
                    rsp_valid_d = 1'b1;
                    rsp_addr_d  = mc_addr_q;
                    rsp_data_d  = mc_rd_data;
                    if (not_empty) begin
                        pop     = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Command outputs: address/data hold between strobes, type drops to 0.
    always_comb begin
        mc_valid_d   = pop;
        mc_rd_wr_d   = pop ? head[EW-1] : 1'b0;
        mc_addr_d    = pop ? head[DATA_WIDTH +: ADDR_WIDTH] : mc_addr_q;
        mc_wr_data_d = pop ? head[DATA_WIDTH-1:0] : mc_wr_data_q;
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            cnt_q        <= '0;
            mc_valid_q   <= 1'b0;
            mc_rd_wr_q   <= 1'b0;
            mc_addr_q    <= '0;
            mc_wr_data_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_addr_q   <= '0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            cnt_q        <= cnt_d;
            mc_valid_q   <= mc_valid_d;
            mc_rd_wr_q   <= mc_rd_wr_d;
            mc_addr_q    <= mc_addr_d;
            mc_wr_data_q <= mc_wr_data_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_addr_q   <= rsp_addr_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

`ifdef MEM_REQ_QUEUE_OVF_EN
    logic ovf_q, ovf_d;

    // Sticky flag for any request offered while the queue is full.
    always_comb begin
        ovf_d = ovf_q | (req_valid & ~req_ready);
    end

    // Overflow flag register, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end

    assign ovf_err = ovf_q;
`else
    assign ovf_err = 1'b0;
`endif

    assign mc_rd_wr_valid = mc_valid_q;
    assign mc_rd_wr       = mc_rd_wr_q;
    assign mc_addr        = mc_addr_q;
    assign mc_wr_data     = mc_wr_data_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_addr       = rsp_addr_q;
    assign rsp_data       = rsp_data_q;
    assign level          = level_q;

endmodule

// File: tb/tb_mem_req_queue.sv
// Testbench for mem_req_queue. Expected commands and responses, each tagged with
// its hand-computed cycle, are queued as stimulus is issued. A monitor compares
// them when the DUT strobes. A small controller model returns read data one
// cycle after a read command.
module tb_mem_req_queue;
    localparam int DW = 8;
    localparam int AW = 16;
    localparam int DEPTH = 4;

    logic clk, reset;
    logic req_valid, req_ready, req_rd_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic mc_rd_wr_valid, mc_rd_wr;
    logic [AW-1:0] mc_addr;
    logic [DW-1:0] mc_wr_data, mc_rd_data;
    logic rsp_valid;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_data;
    logic [$clog2(DEPTH):0] level;
    logic ovf_err;

    mem_req_queue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RD_LATENCY(1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_rd_wr(req_rd_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .mc_rd_wr_valid(mc_rd_wr_valid), .mc_rd_wr(mc_rd_wr), .mc_addr(mc_addr),
        .mc_wr_data(mc_wr_data), .mc_rd_data(mc_rd_data), .rsp_valid(rsp_valid),
        .rsp_addr(rsp_addr), .rsp_data(rsp_data), .level(level), .ovf_err(ovf_err)
    );

    typedef struct { logic rd; logic [AW-1:0] addr; logic [DW-1:0] data; int cyc; } cmd_t;
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; int cyc; } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    int cyc;
    int n_vec, n_err;
    logic [DW-1:0] mem [256];
    logic ovf_exp;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever @(posedge clk) cyc = cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_cmd(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d, input int c);
        cmd_t e;
        e.rd = rd; e.addr = a; e.data = d; e.cyc = c;
        cmd_q.push_back(e);
    endtask

    task automatic exp_rsp(input logic [AW-1:0] a, input logic [DW-1:0] d, input int c);
        rsp_t e;
        e.addr = a; e.data = d; e.cyc = c;
        rsp_q.push_back(e);
    endtask

    task automatic drive(input logic v, input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        req_valid = v; req_rd_wr = rd; req_addr = a; req_wdata = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_mc_valid"}, 32'(mc_rd_wr_valid), 0);
        chk({tag, "_mc_rd_wr"}, 32'(mc_rd_wr), 0);
        chk({tag, "_mc_addr"}, 32'(mc_addr), 0);
        chk({tag, "_mc_wr_data"}, 32'(mc_wr_data), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_rsp_addr"}, 32'(rsp_addr), 0);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 0);
        chk({tag, "_level"}, 32'(level), 0);
        chk({tag, "_ready"}, 32'(req_ready), 1);
        chk({tag, "_ovf_err"}, 32'(ovf_err), 0);
    endtask

    // Monitor and controller model, sampled 2 time units after each rising edge.
    initial begin
        cmd_t c;
        rsp_t r;
        forever begin
            @(posedge clk);
            #2;
            if (!reset) begin
                if (mc_rd_wr_valid) begin
                    if (cmd_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL cmd_unexpected: got addr 0x%0h type %0d, expected no command (cycle %0d)",
                                 mc_addr, mc_rd_wr, cyc);
                    end else begin
                        c = cmd_q.pop_front();
                        chk("cmd_type", 32'(mc_rd_wr), 32'(c.rd));
                        chk("cmd_addr", 32'(mc_addr), 32'(c.addr));
                        if (!c.rd) chk("cmd_wdata", 32'(mc_wr_data), 32'(c.data));
                        chk("cmd_cycle", cyc, c.cyc);
                    end
                    if (mc_rd_wr) mc_rd_data = mem[mc_addr[7:0]];
                    else          mem[mc_addr[7:0]] = mc_wr_data;
                end
                if (rsp_valid) begin
                    if (rsp_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL rsp_unexpected: got addr 0x%0h data 0x%0h, expected no response (cycle %0d)",
                                 rsp_addr, rsp_data, cyc);
                    end else begin
                        r = rsp_q.pop_front();
                        chk("rsp_addr", 32'(rsp_addr), 32'(r.addr));
                        chk("rsp_data", 32'(rsp_data), 32'(r.data));
                        chk("rsp_cycle", cyc, r.cyc);
                    end
                end
            end
        end
    end

    initial begin
        int n, b, w0, f, p, r0;
        n_vec = 0; n_err = 0;
`ifdef MEM_REQ_QUEUE_OVF_EN
        ovf_exp = 1'b1;
`else
        ovf_exp = 1'b0;
`endif
        for (int i = 0; i < 256; i++) mem[i] = DW'(i + 8'h30);
        reset = 1'b1;
        req_valid = 1'b0; req_rd_wr = 1'b0; req_addr = '0; req_wdata = '0;
        mc_rd_data = '0;
        #1;
        chk_reset_state("por");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Idle: nothing pushed for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_mc_valid", 32'(mc_rd_wr_valid), 0);
            chk("idle_level", 32'(level), 0);
            chk("idle_ready", 32'(req_ready), 1);
        end

        // Write then read of addr 20.
        drive(1'b1, 1'b0, 16'd20, 8'd2);
        n = cyc + 1;
        exp_cmd(1'b0, 16'd20, 8'd2, n + 1);
        drive(1'b1, 1'b1, 16'd20, 8'd0);
        exp_cmd(1'b1, 16'd20, 8'd0, n + 2);
        exp_rsp(16'd20, 8'd2, n + 4);
        idle(8);

        // Read blocking: read(22), write(22,4), read(22).
        drive(1'b1, 1'b1, 16'd22, 8'd0);
        b = cyc + 1;
        exp_cmd(1'b1, 16'd22, 8'd0, b + 1);
        exp_rsp(16'd22, 8'h46, b + 3);
        drive(1'b1, 1'b0, 16'd22, 8'd4);
        exp_cmd(1'b0, 16'd22, 8'd4, b + 3);
        drive(1'b1, 1'b1, 16'd22, 8'd0);
        exp_cmd(1'b1, 16'd22, 8'd0, b + 4);
        exp_rsp(16'd22, 8'd4, b + 6);
        idle(8);
        chk("hold_after_read_type", 32'(mc_rd_wr), 0);
        chk("hold_after_read_addr", 32'(mc_addr), 22);

        // Wrap: 12 back-to-back writes, one strobe per cycle.
        w0 = 0;
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, 1'b0, AW'(k), DW'(k + 1));
            if (k == 0) w0 = cyc + 1;
            exp_cmd(1'b0, AW'(k), DW'(k + 1), w0 + 1 + k);
        end
        idle(6);
        chk("hold_after_write_addr", 32'(mc_addr), 11);
        chk("hold_after_write_data", 32'(mc_wr_data), 12);
        chk("hold_after_write_type", 32'(mc_rd_wr), 0);

        // Fill: continuous reads outrun the drain; the 8th offer meets a full queue.
        f = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b1, AW'(100 + k), 8'd0);
            if (k == 0) f = cyc + 1;
            chk("fill_ready", 32'(req_ready), (k < 7) ? 1 : 0);
            if (k < 7) begin
                exp_cmd(1'b1, AW'(100 + k), 8'd0, f + 1 + 2 * k);
                exp_rsp(AW'(100 + k), DW'(100 + k + 8'h30), f + 3 + 2 * k);
            end
            if (k == 7) chk("fill_level_full", 32'(level), 4);
        end
        drive(1'b0, 1'b0, '0, '0);
        chk("fill_level_after_reject", 32'(level), 3);
        chk("fill_ovf_err", 32'(ovf_err), 32'(ovf_exp));
        idle(20);
        chk("fill_drained_level", 32'(level), 0);

        // Reset while a read sits in RD_WAIT.
        drive(1'b1, 1'b1, 16'd50, 8'd0);
        p = cyc + 1;
        exp_cmd(1'b1, 16'd50, 8'd0, p + 1);
        drive(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_reset_state("rst_rdwait");
        @(negedge clk);
        reset = 1'b0;
        req_valid = 1'b1; req_rd_wr = 1'b0; req_addr = 16'd60; req_wdata = 8'd7;
        r0 = cyc + 1;
        exp_cmd(1'b0, 16'd60, 8'd7, r0 + 1);
        idle(10);

        chk("cmd_queue_drained", cmd_q.size(), 0);
        chk("rsp_queue_drained", rsp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
